// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between a requester and the register-file completer.
// Names follow the AMBA signal names so the bridge side wires up one-to-one.
interface apb_slave_regfile_if #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32
);
    logic                      PSEL;
    logic                      PENABLE;
    logic                      PWRITE;
    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [APB_DATA_WIDTH-1:0] PWDATA;
    logic [3:0]                PSTRB;
    logic [APB_DATA_WIDTH-1:0] PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB register-file completer; PREADY WAIT_CYCLES+2 cycles after setup with APB_SLV_WAIT_EN, else 2.
// Flow control is PREADY only; PSEL drop aborts, PSEL&&PENABLE without setup completes with error.
module apb_slave_regfile #(
    parameter int                      APB_ADDR_WIDTH = 32,
    parameter int                      APB_DATA_WIDTH = 32,
    parameter int                      MEM_DEPTH      = 16,
    parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int                      WAIT_CYCLES    = 2
) (
    input  logic                ACLK,
    input  logic                ARESET,
    apb_slave_regfile_if.slave  apb
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [APB_ADDR_WIDTH-1:0] MEM_BYTES = APB_ADDR_WIDTH'(MEM_DEPTH * 4);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic                      err_q, err_d;
    logic                      write_q, write_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [APB_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [APB_DATA_WIDTH-1:0] mem_d [MEM_DEPTH];

    logic [APB_ADDR_WIDTH-1:0] off;
    logic                      dec_err;
    logic [IDX_W-1:0]          dec_idx;

`ifdef APB_SLV_WAIT_EN
    logic [3:0] cnt_q, cnt_d;
`else
    logic [3:0] unused_wait_cycles;
    assign unused_wait_cycles = 4'(WAIT_CYCLES);
`endif

    // Offset wraps modulo the address width, so addresses below BASE_ADDR decode as out of range.
    assign off     = apb.PADDR - BASE_ADDR;
    assign dec_err = (off >= MEM_BYTES) || (apb.PADDR[1:0] != 2'b00);
    assign dec_idx = off[2 +: IDX_W];

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        write_d = write_q;
        idx_d   = idx_q;
        rdata_d = rdata_q;
        mem_d   = mem_q;
`ifdef APB_SLV_WAIT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (apb.PSEL && !apb.PENABLE) begin
                    state_d = S_ACCESS;
                    write_d = apb.PWRITE;
                    err_d   = dec_err;
                    idx_d   = dec_idx;
                    rdata_d = dec_err ? '0 : mem_q[dec_idx];
`ifdef APB_SLV_WAIT_EN
                    cnt_d   = 4'(WAIT_CYCLES);
`endif
                end else if (apb.PSEL && apb.PENABLE) begin
                    // Access phase with no setup: finish at once with an error so the master never hangs.
                    state_d = S_DONE;
                    write_d = apb.PWRITE;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            S_ACCESS: begin
                if (!apb.PSEL) begin
                    state_d = S_IDLE;
                end else if (apb.PENABLE) begin
`ifdef APB_SLV_WAIT_EN
                    if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                    else               state_d = S_DONE;
`else
                    state_d = S_DONE;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (write_q && !err_q) begin
                    for (int k = 0; k < 4; k++) begin
                        if (apb.PSTRB[k]) mem_d[idx_q][8*k +: 8] = apb.PWDATA[8*k +: 8];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
            write_q <= 1'b0;
            idx_q   <= '0;
            rdata_q <= '0;
            mem_q   <= '{default: '0};
`ifdef APB_SLV_WAIT_EN
            cnt_q   <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
            mem_q   <= mem_d;
`ifdef APB_SLV_WAIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign apb.PREADY  = (state_q == S_DONE);
    assign apb.PSLVERR = (state_q == S_DONE) && err_q;
    assign apb.PRDATA  = ((state_q == S_DONE) && !write_q) ? rdata_q : '0;
endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: directed vector table, multi-cycle corner sequences,
// and random transfers checked against an array-based memory model.
module tb_apb_slave_regfile;
    localparam int DEPTH = 16;
    localparam logic [31:0] BASE = 32'h0;
`ifdef APB_SLV_WAIT_EN
    localparam int WAIT    = 2;
    localparam int LAT_EXP = WAIT + 2;
`else
    localparam int WAIT    = 5;
    localparam int LAT_EXP = 2;
`endif

    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   setup_cyc, done_cyc;
    logic [31:0] model_mem [DEPTH];

    apb_slave_regfile_if #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32)) bus ();

    apb_slave_regfile #(
        .APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .MEM_DEPTH(DEPTH),
        .BASE_ADDR(BASE), .WAIT_CYCLES(WAIT)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .apb(bus)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: byte-addressed window of DEPTH words; errors leave memory untouched.
    task automatic model_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, output logic [31:0] rd, output bit err);
        logic [31:0] off;
        int w;
        off = addr - BASE;
        err = (off >= 32'(DEPTH * 4)) || (addr % 4 != 0);
        rd  = 32'h0;
        if (!err) begin
            w = int'(off / 4);
            if (wr) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) model_mem[w][8*b +: 8] = data[8*b +: 8];
            end else begin
                rd = model_mem[w];
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge ACLK);
            bus.PSEL = 1'b0;
            bus.PENABLE = 1'b0;
        end
    endtask

    task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [31:0] rd, output bit err,
                            output int lat);
        @(negedge ACLK);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr;
        bus.PADDR = addr; bus.PWDATA = data; bus.PSTRB = strb;
        setup_cyc = cyc;
        @(negedge ACLK);
        bus.PENABLE = 1'b1;
        lat = 1;
        while (!bus.PREADY && lat < 40) begin
            @(negedge ACLK);
            lat++;
        end
        rd = bus.PRDATA;
        err = bus.PSLVERR;
        done_cyc = cyc;
        if (!bus.PREADY) lat = -1;
    endtask

    task automatic run_and_check(input string tag, input bit wr, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] rd, erd;
        bit err, eerr;
        int lat;
        model_xfer(wr, addr, data, strb, erd, eerr);
        apb_xfer(wr, addr, data, strb, rd, err, lat);
        check({tag, "_rdata"}, rd, erd);
        check({tag, "_slverr"}, 32'(err), 32'(eerr));
        check({tag, "_latency"}, 32'(lat), 32'(LAT_EXP));
    endtask

    initial begin
        vec_t tbl[$];
        logic [31:0] rd, addr;
        bit err;
        int lat, prev_done, sel, any_ready;

        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = '0; bus.PWDATA = '0; bus.PSTRB = '0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;

        tbl.push_back(vec_t'{1'b0, 32'h10,       32'h0,        4'hF,    32'h0,        1'b0});
        tbl.push_back(vec_t'{1'b1, 32'h8,        32'hABABCDCD, 4'hF,    32'h0,        1'b0});
        tbl.push_back(vec_t'{1'b0, 32'h8,        32'h0,        4'hF,    32'hABABCDCD, 1'b0});
        tbl.push_back(vec_t'{1'b1, 32'h0,        32'hFFFFFFFF, 4'hF,    32'h0,        1'b0});
        tbl.push_back(vec_t'{1'b1, 32'h0,        32'h11223344, 4'b0101, 32'h0,        1'b0});
        tbl.push_back(vec_t'{1'b0, 32'h0,        32'h0,        4'hF,    32'hFF22FF44, 1'b0});
        tbl.push_back(vec_t'{1'b1, 32'h40,       32'hDEADBEEF, 4'hF,    32'h0,        1'b1});
        tbl.push_back(vec_t'{1'b0, 32'h9,        32'h0,        4'hF,    32'h0,        1'b1});
        tbl.push_back(vec_t'{1'b1, 32'h6,        32'h55555555, 4'hF,    32'h0,        1'b1});
        tbl.push_back(vec_t'{1'b0, 32'h8,        32'h0,        4'hF,    32'hABABCDCD, 1'b0});
        tbl.push_back(vec_t'{1'b1, 32'h3C,       32'h12345678, 4'b1000, 32'h0,        1'b0});
        tbl.push_back(vec_t'{1'b0, 32'h3C,       32'h0,        4'hF,    32'h12000000, 1'b0});
        tbl.push_back(vec_t'{1'b0, 32'hFFFFFFFC, 32'h0,        4'hF,    32'h0,        1'b1});
        tbl.push_back(vec_t'{1'b0, 32'h0,        32'h0,        4'hF,    32'hFF22FF44, 1'b0});

        // Reset state
        repeat (3) @(negedge ACLK);
        check("rst_pready", 32'(bus.PREADY), 32'h0);
        check("rst_pslverr", 32'(bus.PSLVERR), 32'h0);
        check("rst_prdata", bus.PRDATA, 32'h0);
        ARESET = 1'b0;
        @(negedge ACLK);
        check("post_rst_pready", 32'(bus.PREADY), 32'h0);

        // Directed table
        foreach (tbl[i]) begin
            logic [31:0] mrd;
            bit merr;
            model_xfer(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].strb, mrd, merr);
            apb_xfer(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].strb, rd, err, lat);
            check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
            check($sformatf("vec%0d_slverr", i), 32'(err), 32'(tbl[i].exp_err));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT_EXP));
            idle(1);
        end

        // Back-to-back burst: 8 writes then 8 reads with no idle cycles
        for (int i = 0; i < 8; i++) begin
            model_xfer(1'b1, 32'(4 * i), 32'(i + 1), 4'hF, rd, err);
            apb_xfer(1'b1, 32'(4 * i), 32'(i + 1), 4'hF, rd, err, lat);
            if (i > 0) check($sformatf("bw%0d_gap", i), 32'(setup_cyc - prev_done), 32'h1);
            prev_done = done_cyc;
        end
        for (int i = 0; i < 8; i++) begin
            apb_xfer(1'b0, 32'(4 * i), 32'h0, 4'hF, rd, err, lat);
            check($sformatf("br%0d_data", i), rd, 32'(i + 1));
            check($sformatf("br%0d_gap", i), 32'(setup_cyc - prev_done), 32'h1);
            prev_done = done_cyc;
        end
        idle(1);

        // Access phase without setup: immediate error response, no write
        @(negedge ACLK);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PWRITE = 1'b1;
        bus.PADDR = 32'h0; bus.PWDATA = 32'hDEAD0000; bus.PSTRB = 4'hF;
        @(negedge ACLK);
        check("viol_pready", 32'(bus.PREADY), 32'h1);
        check("viol_pslverr", 32'(bus.PSLVERR), 32'h1);
        check("viol_prdata", bus.PRDATA, 32'h0);
        idle(1);
        run_and_check("viol_readback", 1'b0, 32'h0, 32'h0, 4'hF);
        idle(1);

        // Random traffic
        for (int i = 0; i < 120; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)       addr = {26'h0, 4'($urandom_range(0, DEPTH - 1)), 2'b00};
            else if (sel == 7) addr = {26'h0, 4'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
            else if (sel == 8) addr = 32'h40 + {$urandom_range(0, 1000), 2'b00};
            else               addr = $urandom;
            run_and_check($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), addr, $urandom,
                          4'($urandom_range(0, 15)));
            idle($urandom_range(0, 2));
        end
        idle(1);

        // Master abort: PSEL dropped after setup
        @(negedge ACLK);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
        bus.PADDR = 32'h4; bus.PWDATA = 32'hAAAA5555; bus.PSTRB = 4'hF;
        @(negedge ACLK);
        bus.PSEL = 1'b0;
        any_ready = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            if (bus.PREADY) any_ready = 1;
        end
        check("abort_no_pready", 32'(any_ready), 32'h0);
        run_and_check("abort_readback", 1'b0, 32'h4, 32'h0, 4'hF);
        idle(1);

        // Reset pulsed in the access phase of a write
        @(negedge ACLK);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
        bus.PADDR = 32'h8; bus.PWDATA = 32'h5A5A5A5A; bus.PSTRB = 4'hF;
        @(negedge ACLK);
        bus.PENABLE = 1'b1;
        ARESET = 1'b1;
        #1;
        check("midrst_pready", 32'(bus.PREADY), 32'h0);
        check("midrst_prdata", bus.PRDATA, 32'h0);
        @(negedge ACLK);
        ARESET = 1'b0;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        @(negedge ACLK);
        check("postrst_pslverr", 32'(bus.PSLVERR), 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            apb_xfer(1'b0, 32'(4 * i), 32'h0, 4'hF, rd, err, lat);
            check($sformatf("clr%0d_data", i), rd, 32'h0);
            check($sformatf("clr%0d_latency", i), 32'(lat), 32'(LAT_EXP));
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
